// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the program-counter generator.
// Latency: n/a (declarations only).
// Backpressure: n/a. Optional feature macro: PC_GEN_MISALIGN_CHECK_EN.
package pc_gen_pkg;

    // Fetch-loop phases: BOOT after reset, ISSUE while offering pc_o, WAIT_COMMIT until retirement
    typedef enum logic [1:0] {
        BOOT        = 2'd0,
        ISSUE       = 2'd1,
        WAIT_COMMIT = 2'd2
    } pc_state_e;

    // Reset vectors for the two build flavours
    localparam logic [31:0] RESET_VEC_SOC = 32'h3000_0000;
    localparam logic [31:0] RESET_VEC_SIM = 32'h8000_0000;

    // Ceiling log2, used to size the instruction alignment mask
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pc_gen_nextsel.sv
// Next-PC selector: trap target, then branch target, then pc + ILEN_BYTES.
// Latency: purely combinational, consumed at the commit edge in pc_gen.
// Backpressure: none; PC_GEN_MISALIGN_CHECK_EN adds target alignment and a misalign flag.
module pc_gen_nextsel
    import pc_gen_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ILEN_BYTES = 4
) (
    input  logic [DATA_WIDTH-1:0] pc_i,
    input  logic                  br_taken_i,
    input  logic [DATA_WIDTH-1:0] br_target_i,
    input  logic                  trap_i,
    input  logic [DATA_WIDTH-1:0] trap_target_i,
`ifdef PC_GEN_MISALIGN_CHECK_EN
    output logic                  misalign_o,
    output logic [DATA_WIDTH-1:0] misalign_addr_o,
`endif
    output logic [DATA_WIDTH-1:0] next_pc_o
);

`ifdef PC_GEN_MISALIGN_CHECK_EN
    // Low address bits that must be zero for an instruction-aligned PC
    localparam int                  ALIGN_BITS = clog2(ILEN_BYTES);
    localparam logic [DATA_WIDTH-1:0] LOW_MASK =
        {{(DATA_WIDTH - ALIGN_BITS){1'b0}}, {ALIGN_BITS{1'b1}}};
`endif

    logic                  redirect;
    logic [DATA_WIDTH-1:0] target;
    logic [DATA_WIDTH-1:0] seq_pc;

    // Priority mux: a trap always overrides a simultaneous branch; sequential wraps silently
    always_comb begin
        redirect = trap_i | br_taken_i;
        target   = trap_i ? trap_target_i : br_target_i;
        seq_pc   = pc_i + DATA_WIDTH'(ILEN_BYTES);
`ifdef PC_GEN_MISALIGN_CHECK_EN
        next_pc_o       = redirect ? (target & ~LOW_MASK) : seq_pc;
        misalign_o      = redirect && ((target & LOW_MASK) != '0);
        misalign_addr_o = target;
`else
        next_pc_o       = redirect ? target : seq_pc;
`endif
    end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: offers one fetch address, holds it until commit, then redirects.
// Latency: new PC valid one cycle after the commit edge; loop = handshake edge + commit edge.
// Backpressure: pc_o held stable while pc_valid_o && !pc_ready_i. Macro: PC_GEN_MISALIGN_CHECK_EN.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] RESET_VEC  = RESET_VEC_SIM,
    parameter int          ILEN_BYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic                  pc_valid_o,
    input  logic                  pc_ready_i,
    input  logic                  commit_i,
    input  logic                  br_taken_i,
    input  logic [DATA_WIDTH-1:0] br_target_i,
    input  logic                  trap_i,
    input  logic [DATA_WIDTH-1:0] trap_target_i,
    output logic                  busy_o,
    output logic                  proto_err_o,
    output logic                  misalign_o,
    output logic [DATA_WIDTH-1:0] misalign_addr_o
);

    localparam logic [DATA_WIDTH-1:0] RESET_PC = DATA_WIDTH'(RESET_VEC);

    pc_state_e             state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic                  pc_valid_q, pc_valid_d;
    logic                  busy_q, busy_d;
    logic                  proto_err_q, proto_err_d;
    logic [DATA_WIDTH-1:0] next_pc;
    logic                  commit_ok;
    logic                  handshake;

    // Only a commit seen in WAIT_COMMIT retires the held PC
    assign commit_ok = (state_q == WAIT_COMMIT) && commit_i;
    assign handshake = (state_q == ISSUE) && pc_ready_i;

`ifdef PC_GEN_MISALIGN_CHECK_EN
    logic                  sel_misalign;
    logic [DATA_WIDTH-1:0] sel_raw;
    logic                  misalign_q, misalign_d;
    logic [DATA_WIDTH-1:0] misalign_addr_q, misalign_addr_d;
`endif

    pc_gen_nextsel #(
        .DATA_WIDTH (DATA_WIDTH),
        .ILEN_BYTES (ILEN_BYTES)
    ) u_nextsel (
        .pc_i            (pc_q),
        .br_taken_i      (br_taken_i),
        .br_target_i     (br_target_i),
        .trap_i          (trap_i),
        .trap_target_i   (trap_target_i),
`ifdef PC_GEN_MISALIGN_CHECK_EN
        .misalign_o      (sel_misalign),
        .misalign_addr_o (sel_raw),
`endif
        .next_pc_o       (next_pc)
    );

    // State register; reset discards any in-flight fetch or commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: BOOT lasts one cycle, then alternate offer / wait-for-retire
    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:        state_d = ISSUE;
            ISSUE:       if (handshake) state_d = WAIT_COMMIT;
            WAIT_COMMIT: if (commit_ok) state_d = ISSUE;
            default:     state_d = BOOT;
        endcase
    end

    // Output next-values, derived from the upcoming state so every output is a flop
    always_comb begin
        pc_d        = commit_ok ? next_pc : pc_q;
        pc_valid_d  = (state_d == ISSUE);
        busy_d      = (state_d == WAIT_COMMIT);
        proto_err_d = commit_i && (state_q != WAIT_COMMIT);
`ifdef PC_GEN_MISALIGN_CHECK_EN
        misalign_d      = commit_ok && sel_misalign;
        misalign_addr_d = misalign_d ? sel_raw : misalign_addr_q;
`endif
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            pc_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            pc_valid_q  <= pc_valid_d;
            busy_q      <= busy_d;
            proto_err_q <= proto_err_d;
        end
    end

`ifdef PC_GEN_MISALIGN_CHECK_EN
    // Misalign pulse lines up with the aligned PC; the raw address is held until the next event
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q      <= 1'b0;
            misalign_addr_q <= '0;
        end else begin
            misalign_q      <= misalign_d;
            misalign_addr_q <= misalign_addr_d;
        end
    end

    assign misalign_o      = misalign_q;
    assign misalign_addr_o = misalign_addr_q;
`else
    assign misalign_o      = 1'b0;
    assign misalign_addr_o = '0;
`endif

    assign pc_o        = pc_q;
    assign pc_valid_o  = pc_valid_q;
    assign busy_o      = busy_q;
    assign proto_err_o = proto_err_q;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: expected fetch addresses are queued at commit and
// popped by a monitor on every accepted fetch; per-cycle flags are checked alongside.
// Optional feature macro: PC_GEN_MISALIGN_CHECK_EN.
module tb_pc_gen;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc_o;
    logic        pc_valid_o;
    logic        pc_ready_i = 1'b0;
    logic        commit_i = 1'b0;
    logic        br_taken_i = 1'b0;
    logic [31:0] br_target_i = '0;
    logic        trap_i = 1'b0;
    logic [31:0] trap_target_i = '0;
    logic        busy_o;
    logic        proto_err_o;
    logic        misalign_o;
    logic [31:0] misalign_addr_o;

    always #5 clk = ~clk;

    pc_gen #(
        .DATA_WIDTH (32),
        .RESET_VEC  (32'h8000_0000),
        .ILEN_BYTES (4)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pc_o            (pc_o),
        .pc_valid_o      (pc_valid_o),
        .pc_ready_i      (pc_ready_i),
        .commit_i        (commit_i),
        .br_taken_i      (br_taken_i),
        .br_target_i     (br_target_i),
        .trap_i          (trap_i),
        .trap_target_i   (trap_target_i),
        .busy_o          (busy_o),
        .proto_err_o     (proto_err_o),
        .misalign_o      (misalign_o),
        .misalign_addr_o (misalign_addr_o)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] m_pc = RST_PC;
    bit          m_waiting = 0;
    bit          nxt_commit = 0, nxt_proto = 0, nxt_mis = 0;
    logic [31:0] nxt_mis_addr = '0;
    bit          pend_commit = 0, pend_proto = 0, pend_mis = 0;
    logic [31:0] pend_mis_addr = '0;
    logic [31:0] exp_mis_addr = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference rule: trap beats branch beats pc+4; optionally clear the low two bits of a redirect
    function automatic logic [31:0] ref_next(input logic [31:0] pc, input bit tr,
                                             input logic [31:0] tt, input bit br,
                                             input logic [31:0] bt, output bit mis);
        logic [31:0] tgt;
        mis = 1'b0;
        if (!tr && !br) return pc + 32'd4;
        tgt = tr ? tt : bt;
`ifdef PC_GEN_MISALIGN_CHECK_EN
        if (tgt % 4 != 0) begin
            mis = 1'b1;
            return tgt - (tgt % 4);
        end
`endif
        return tgt;
    endfunction

    function automatic logic [31:0] rand_tgt();
        logic [31:0] t;
        t = $urandom();
        if ($urandom_range(0, 3) != 0) t = t & 32'hFFFF_FFFC;
        return t;
    endfunction

    // One clock of stimulus, driven on the falling edge
    task automatic cycle(input bit rdy, input bit com, input bit tr, input logic [31:0] tt,
                         input bit br, input logic [31:0] bt);
        bit          mis;
        logic [31:0] nxt;
        @(negedge clk);
        chk1("busy_o", busy_o, m_waiting);
        pc_ready_i    = rdy;
        commit_i      = com;
        trap_i        = tr;
        trap_target_i = tt;
        br_taken_i    = br;
        br_target_i   = bt;
        if (com && m_waiting) begin
            nxt = ref_next(m_pc, tr, tt, br, bt, mis);
            exp_q.push_back(nxt);
            m_pc         = nxt;
            m_waiting    = 0;
            nxt_commit   = 1;
            nxt_mis      = mis;
            nxt_mis_addr = tr ? tt : bt;
        end else if (com) begin
            nxt_proto = 1;
        end
    endtask

    task automatic wait_fetch();
        int n;
        n = 0;
        while (!m_waiting && n < 20) begin
            cycle(1, 0, 0, '0, 0, '0);
            n++;
        end
        if (!m_waiting) begin
            n_cmp++;
            n_err++;
            $display("FAIL fetch_timeout: no handshake within 20 cycles, expected pc %h", m_pc);
        end
    endtask

    task automatic cmt(input bit tr, input logic [31:0] tt, input bit br, input logic [31:0] bt);
        cycle(0, 1, tr, tt, br, bt);
    endtask

    task automatic do_reset(input bit mid);
        @(negedge clk);
        #2;
        if (mid) chk1("pre_reset_busy", busy_o, 1'b1);
        rst_n      = 1'b0;
        pc_ready_i = 1'b0;
        commit_i   = 1'b0;
        trap_i     = 1'b0;
        br_taken_i = 1'b0;
        #1;
        chk("rst_pc_o", pc_o, RST_PC);
        chk1("rst_pc_valid_o", pc_valid_o, 1'b0);
        chk1("rst_busy_o", busy_o, 1'b0);
        chk1("rst_proto_err_o", proto_err_o, 1'b0);
        chk1("rst_misalign_o", misalign_o, 1'b0);
        chk("rst_misalign_addr_o", misalign_addr_o, 32'h0);
        exp_q.delete();
        exp_q.push_back(RST_PC);
        m_pc         = RST_PC;
        m_waiting    = 0;
        exp_mis_addr = '0;
        nxt_commit   = 0;
        nxt_proto    = 0;
        nxt_mis      = 0;
        @(negedge clk);
        @(negedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        chk1("boot_pc_valid_o", pc_valid_o, 1'b0);
        @(negedge clk);
        chk1("first_pc_valid_o", pc_valid_o, 1'b1);
        chk("first_pc_o", pc_o, RST_PC);
    endtask

    // Monitor: per-cycle flag checks and scoreboard pop on every accepted fetch
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                pend_commit = 0;
                pend_proto  = 0;
                pend_mis    = 0;
                nxt_commit  = 0;
                nxt_proto   = 0;
                nxt_mis     = 0;
            end else begin
                if (pend_commit) chk1("valid_after_commit", pc_valid_o, 1'b1);
                chk1("proto_err_o", proto_err_o, pend_proto);
                if (pend_mis) exp_mis_addr = pend_mis_addr;
                chk1("misalign_o", misalign_o, pend_mis);
                chk("misalign_addr_o", misalign_addr_o, exp_mis_addr);
                if (pc_valid_o && pc_ready_i) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_fetch: pc_o %h accepted, none expected", pc_o);
                    end else begin
                        chk("fetch_pc", pc_o, exp_q.pop_front());
                    end
                    m_waiting = 1;
                end
                pend_commit   = nxt_commit;
                pend_proto    = nxt_proto;
                pend_mis      = nxt_mis;
                pend_mis_addr = nxt_mis_addr;
                nxt_commit    = 0;
                nxt_proto     = 0;
                nxt_mis       = 0;
            end
        end
    end

    initial begin
        do_reset(0);
        wait_fetch();                                   // 8000_0000
        cmt(0, '0, 0, '0);                              // -> 8000_0004
        wait_fetch();
        cmt(0, '0, 0, '0);                              // -> 8000_0008
        wait_fetch();
        cmt(1, 32'h8000_0400, 1, 32'h8000_0100);        // trap wins
        wait_fetch();
        cmt(0, '0, 1, 32'hFFFF_FFFC);
        wait_fetch();
        cmt(0, '0, 0, '0);                              // wraps to 0
        wait_fetch();
        cmt(0, '0, 0, '0);                              // -> 4, now in ISSUE
        cycle(0, 1, 1, 32'h1234_5678, 1, 32'h8765_4320); // commit during ISSUE
        cycle(0, 0, 0, '0, 0, '0);
        wait_fetch();                                   // still 4
        do_reset(1);                                    // reset mid-WAIT_COMMIT
        wait_fetch();
        cmt(0, '0, 1, 32'h8000_0102);                   // misaligned branch target
        wait_fetch();

        for (int i = 0; i < 600; i++) begin
            bit rdy, com, tr, br;
            rdy = ($urandom_range(0, 9) < 7);
            com = m_waiting ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 19) == 0);
            tr  = ($urandom_range(0, 7) == 0);
            br  = ($urandom_range(0, 2) == 0);
            cycle(rdy, com, tr, rand_tgt(), br, rand_tgt());
        end

        for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
            cycle(1, 0, 0, '0, 0, '0);
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d expected fetches never offered, next %h", exp_q.size(), exp_q[0]);
        end
        cycle(0, 0, 0, '0, 0, '0);
        cycle(0, 0, 0, '0, 0, '0);
        @(negedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised program-counter generator for the multi-cycle core; successor to the single-issue PC register.
- Issues a fetch address to the IFU over a valid/ready handshake.
- Holds that address until the writeback stage reports commit, then selects the next PC: trap target first, branch target second, sequential otherwise.
- Sits between WBU/EXU (redirect sources) and IFU (fetch address consumer).

Parameters:
- DATA_WIDTH, 32, width of PC and all target buses.
- RESET_VEC, 32'h8000_0000, PC value loaded by reset (truncated to DATA_WIDTH).
- ILEN_BYTES, 4, sequential increment in bytes; must be a power of two, 2 or 4.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- pc_o  out  DATA_WIDTH  current fetch address.
- pc_valid_o  out  1  pc_o is offered to the IFU.
- pc_ready_i  in  1  IFU accepts pc_o.
- commit_i  in  1  one-cycle pulse: instruction at pc_o has retired.
- br_taken_i  in  1  qualifies br_target_i, sampled with commit_i.
- br_target_i  in  DATA_WIDTH  branch/jump target.
- trap_i  in  1  qualifies trap_target_i, sampled with commit_i.
- trap_target_i  in  DATA_WIDTH  mtvec/mepc target.
- busy_o  out  1  high in WAIT_COMMIT.
- proto_err_o  out  1  one-cycle pulse when commit_i arrives outside WAIT_COMMIT.
- misalign_o  out  1  misalignment pulse (optional feature).
- misalign_addr_o  out  DATA_WIDTH  offending target (optional feature).

Behaviour:
- Reset (async, rst_n=0):
  - pc_o=RESET_VEC, state=BOOT.
  - pc_valid_o, busy_o, proto_err_o and misalign_o = 0; misalign_addr_o = 0.
  - Applies immediately and mid-operation; any in-flight fetch or commit is discarded.
- States BOOT, ISSUE, WAIT_COMMIT:
  - BOOT: one cycle after reset release, pc_valid_o=0; unconditionally -> ISSUE.
  - ISSUE: pc_valid_o=1 and pc_o held stable. On pc_valid_o&&pc_ready_i at an edge -> WAIT_COMMIT. pc_valid_o falls the next cycle.
  - WAIT_COMMIT: pc_valid_o=0, busy_o=1. On commit_i, pc_o loads next_pc at the edge and state -> ISSUE. The new PC is valid one cycle after the commit edge.
- next_pc priority:
  - trap_i: trap_target_i.
  - else br_taken_i: br_target_i.
  - else pc_o+ILEN_BYTES, modulo 2^DATA_WIDTH (wrap from all-ones region to 0, no flag).
  - trap_i and br_taken_i together: trap wins; branch ignored.
- trap_i/br_taken_i without commit_i: ignored.
- commit_i in BOOT or ISSUE: ignored for PC purposes; proto_err_o pulses the following cycle.
- pc_ready_i outside ISSUE: ignored.
- Latency: commit to next valid fetch = 1 cycle; minimum loop = handshake edge + commit edge.
- All outputs registered; no combinational in->out paths.

Optional Feature:
- Macro PC_GEN_MISALIGN_CHECK_EN.
- Defined:
  - Any selected redirect target with low log2(ILEN_BYTES) bits nonzero is loaded into pc_o with those bits cleared.
  - misalign_o pulses one cycle, coincident with the new pc_o.
  - misalign_addr_o captures the raw target and holds it until the next misalignment or reset.
  - The sequential path never flags.
- Undefined: targets are loaded verbatim; misalign_o and misalign_addr_o tied to 0.

Decomposition:
- Shared package pc_gen_pkg:
  - state enum {BOOT, ISSUE, WAIT_COMMIT}, 2 bits.
  - Default reset vector constants for SoC (32'h3000_0000) and sim (32'h8000_0000) builds.
  - Function clog2 for the alignment mask.
- One sub-module, pc_gen_nextsel: combinational priority mux, increment, alignment mask. The FSM and registers stay in pc_gen.

Test Plan:
- Reset release, pc_ready_i=1 -> pc_valid_o rises 1 cycle after BOOT with pc_o=32'h8000_0000; handshake accepted; busy_o=1.
- Commit with no redirect -> pc_o=32'h8000_0004 and pc_valid_o=1 the cycle after commit; repeat to reach 32'h8000_0008.
- Commit with br_taken_i=1, br_target_i=32'h8000_0100, trap_i=1, trap_target_i=32'h8000_0400 -> pc_o=32'h8000_0400 (trap priority).
- pc_o=32'hFFFF_FFFC, plain commit -> pc_o=32'h0000_0000, no flag.
- commit_i pulsed during ISSUE -> pc_o unchanged, proto_err_o=1 for one cycle; rst_n driven low mid-WAIT_COMMIT -> pc_o=32'h8000_0000 and pc_valid_o=0 immediately (before the next edge).
- With PC_GEN_MISALIGN_CHECK_EN, branch target 32'h8000_0102 -> pc_o=32'h8000_0100, misalign_o=1 one cycle, misalign_addr_o=32'h8000_0102; without the macro, pc_o=32'h8000_0102 and misalign_o=0.
